mix_column_ctrl: RTL and testbench

Sequencer for AES MixColumns over one shared GF(2^8) byte-multiplier (x1/x2/x3 unit, 2-bit op select) that sits outside this block. Accepts a 32-bit state column over a valid/ready handshake and issues the 16 byte-multiplies serially, one per cycle. XOR-accumulates the products into the 4 output bytes and returns the mixed column over a second valid/ready handshake. Sits between the AES round controller and the multiplier; it is the only master of the multiplier.

---
 rtl/mix_column_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mix_column_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_ctrl.sv
// -----------------------------------------------------------------------------
// mix_column_ctrl
//
// Sequencer for AES MixColumns over one external GF(2^8) byte multiplier
// (x1/x2/x3). A 32-bit column is accepted over a valid/ready handshake. The
// 16 byte products are issued serially, one per cycle, and XOR-accumulated
// into the four output bytes. The mixed column is returned over a second
// valid/ready handshake. This block is the only master of the multiplier.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high. Valid, once raised, holds its data stable until that edge.
// Ready may be asserted independently of valid.
//
// Optional feature (define MIX_PREFETCH_EN):
//   One-entry input buffer. The next column can be accepted while a column
//   is being computed or waiting for output. That column then starts straight
//   after the output handshake, with no IDLE cycle.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   in_valid_i   column_i valid
//   in_ready_o   block can accept a column
//   column_i     input column, [31:24]=a0 (row0) ... [7:0]=a3
//   out_valid_o  column_o valid
//   out_ready_i  consumer accepts column_o
//   column_o     mixed column, same byte order
//   mix_num_o    operand byte to the multiplier
//   mix_state_o  multiplier op select: 01 x1, 10 x2, 11 x3, 00 idle
//   mix_res_i    multiplier product (combinational from mix_num_o/mix_state_o)
//   busy_o       high while computing or holding a result
// -----------------------------------------------------------------------------
module mix_column_ctrl #(
   parameter  int WIDTH    = 8,
   parameter  int S_LENGTH = 2,
   localparam int COL_W    = 4*WIDTH
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [COL_W-1:0]    column_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [COL_W-1:0]    column_o,
   output logic [WIDTH-1:0]    mix_num_o,
   output logic [S_LENGTH-1:0] mix_state_o,
   input  logic [WIDTH-1:0]    mix_res_i,
   output logic                busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q;
   logic [WIDTH-1:0] acc_q;
   logic [COL_W-1:0] col_q;
   logic [COL_W-1:0] res_q;

   logic [1:0]       row;
   logic [1:0]       byte_sel;
   logic [1:0]       coef;
   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] byte_sum;

   // Counter k: upper two bits pick the output row, lower two the input byte.
   assign row      = cnt_q[3:2];
   assign byte_sel = cnt_q[1:0];
   // (c - r) mod 4 falls out of the 2-bit wrap.
   assign coef     = byte_sel - row;
   assign byte_sum = acc_q ^ mix_res_i;

   assign in_fire  = in_valid_i & in_ready_o;
   assign out_fire = out_valid_o & out_ready_i;

   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign column_o    = res_q;

`ifdef MIX_PREFETCH_EN
   logic             buf_valid_q;
   logic [COL_W-1:0] buf_q;

   assign in_ready_o = (state_q == IDLE) | ~buf_valid_q;
`else
   assign in_ready_o = (state_q == IDLE);
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_fire) state_d = CALC;
         CALC: if (cnt_q == 4'd15) state_d = DONE;
         DONE: begin
            if (out_fire) begin
`ifdef MIX_PREFETCH_EN
               state_d = (buf_valid_q | in_fire) ? CALC : IDLE;
`else
               state_d = IDLE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Multiplier drive: operand byte a[c] and its coefficient for row r.
   always_comb begin
      mix_num_o   = '0;
      mix_state_o = '0;
      if (state_q == CALC) begin
         case (byte_sel)
            2'd0:    mix_num_o = col_q[4*WIDTH-1:3*WIDTH];
            2'd1:    mix_num_o = col_q[3*WIDTH-1:2*WIDTH];
            2'd2:    mix_num_o = col_q[2*WIDTH-1:WIDTH];
            default: mix_num_o = col_q[WIDTH-1:0];
         endcase
         case (coef)
            2'd0:    mix_state_o = S_LENGTH'(2'b10);
            2'd1:    mix_state_o = S_LENGTH'(2'b11);
            default: mix_state_o = S_LENGTH'(2'b01);
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         col_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_fire) begin
                  col_q <= column_i;
                  cnt_q <= '0;
                  acc_q <= '0;
               end
            end
            CALC: begin
               cnt_q <= cnt_q + 4'd1;
               // First product of a row restarts the sum.
               acc_q <= (byte_sel == 2'd0) ? mix_res_i : byte_sum;
               if (byte_sel == 2'd3) begin
                  case (row)
                     2'd0:    res_q[4*WIDTH-1:3*WIDTH] <= byte_sum;
                     2'd1:    res_q[3*WIDTH-1:2*WIDTH] <= byte_sum;
                     2'd2:    res_q[2*WIDTH-1:WIDTH]   <= byte_sum;
                     default: res_q[WIDTH-1:0]         <= byte_sum;
                  endcase
               end
            end
            DONE: begin
`ifdef MIX_PREFETCH_EN
               // A column arriving on the same edge as the output handshake
               // bypasses the (empty) buffer.
               if (out_fire && (buf_valid_q || in_fire)) begin
                  col_q <= in_fire ? column_i : buf_q;
                  cnt_q <= '0;
                  acc_q <= '0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

`ifdef MIX_PREFETCH_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         buf_valid_q <= 1'b0;
         buf_q       <= '0;
      end else begin
         if (in_fire && (state_q != IDLE) && !((state_q == DONE) && out_fire)) begin
            buf_q       <= column_i;
            buf_valid_q <= 1'b1;
         end else if ((state_q == DONE) && out_fire) begin
            buf_valid_q <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mix_column_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mix_column_ctrl
//
// Directed bench for mix_column_ctrl. Hosts a behavioural GF(2^8) x1/x2/x3
// multiplier, drives columns through the input handshake and scores returned
// columns against an expected queue filled when each column is sent.
// -----------------------------------------------------------------------------
module tb_mix_column_ctrl;

   localparam int WIDTH = 8;
   localparam int COL_W = 32;

`ifdef MIX_PREFETCH_EN
   localparam int   B2B_GAP    = 17;
   localparam logic HOLD_READY = 1'b1;
`else
   localparam int   B2B_GAP    = 18;
   localparam logic HOLD_READY = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic             in_valid;
   logic             in_ready;
   logic [COL_W-1:0] column_in;
   logic             out_valid;
   logic             out_ready;
   logic [COL_W-1:0] column_out;
   logic [WIDTH-1:0] mix_num;
   logic [1:0]       mix_state;
   logic [WIDTH-1:0] mix_res;
   logic             busy;

   mix_column_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .column_i    (column_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .column_o    (column_out),
      .mix_num_o   (mix_num),
      .mix_state_o (mix_state),
      .mix_res_i   (mix_res),
      .busy_o      (busy)
   );

   // ---------------- multiplier and reference model ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Idle op select returns junk so any use of it outside CALC is visible.
   always_comb begin
      case (mix_state)
         2'b01:   mix_res = mix_num;
         2'b10:   mix_res = xt(mix_num);
         2'b11:   mix_res = xt(mix_num) ^ mix_num;
         default: mix_res = 8'h5a;
      endcase
   end

   function automatic logic [31:0] ref_mix(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [COL_W-1:0] exp_q[$];
   int               out_cyc_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output transfers happen on the next rising edge; sample on the falling one.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         out_cyc_q.push_back(cyc + 1);
         if (exp_q.size() == 0)
            check("sb_unexpected_output", 32'(exp_q.size()), 32'd1);
         else
            check("sb_column", column_out, exp_q.pop_front());
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [31:0] exp, output int acc_cyc);
      int n;
      n = 0;
      exp_q.push_back(exp);
      in_valid  = 1'b1;
      column_in = d;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      check("accept_timeout", 32'(n < 100), 32'd1);
      tick();
      acc_cyc   = cyc;
      in_valid  = 1'b0;
      column_in = $urandom;
   endtask

   task automatic wait_valid(output int c);
      int n;
      n = 0;
      while (!out_valid && n < 64) begin
         tick();
         n++;
      end
      check("valid_timeout", 32'(n < 64), 32'd1);
      c = cyc;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      check("drain_timeout", 32'(n < 200), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
      check({tag, "_mix_num"},   32'(mix_num),   32'd0);
      check({tag, "_mix_state"}, 32'(mix_state), 32'd0);
      check({tag, "_column"},    column_out,     32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int e, c, v;
      logic [31:0] held, r;
      logic [1:0]  row0_sel [4];
      logic [7:0]  row0_num [4];
      row0_sel = '{2'b10, 2'b11, 2'b01, 2'b01};
      row0_num = '{8'hdb, 8'h13, 8'h53, 8'h45};

      in_valid  = 1'b0;
      out_ready = 1'b0;
      column_in = '0;

      // Reset values
      tick(); tick(); tick();
      check_reset_outputs("rst");
      #2 rst = 1'b0;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // First column: row0 multiplier sequence and latency
      out_ready = 1'b1;
      send(32'hdb135345, 32'h8e4da1bc, e);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("row0_sel_k%0d", i), 32'(mix_state), 32'(row0_sel[i]));
         check($sformatf("row0_num_k%0d", i), 32'(mix_num),   32'(row0_num[i]));
         tick();
      end
      check("row1_k4_sel", 32'(mix_state), 32'(2'b01));
      check("calc_busy",   32'(busy),      32'd1);
      wait_valid(c);
      check("latency", 32'(c - e), 32'd16);
      wait_drain();
      check("idle_keeps_result", column_out, 32'h8e4da1bc);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_mix_state", 32'(mix_state), 32'd0);

      // Known vectors
      send(32'hf20a225c, 32'h9fdc589d, e);
      wait_drain();
      send(32'hd4bf5d30, 32'h046681e5, e);
      wait_drain();
      send(32'h01010101, 32'h01010101, e);
      wait_drain();

      // Output back-pressure: result held while out_ready is low
      out_ready = 1'b0;
      send(32'hc6c6c6c6, 32'hc6c6c6c6, e);
      wait_valid(c);
      held = column_out;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_column",    column_out,      held);
         check("hold_valid",     32'(out_valid),  32'd1);
         check("hold_in_ready",  32'(in_ready),   32'(HOLD_READY));
      end
      check("hold_value", held, 32'hc6c6c6c6);
      out_ready = 1'b1;
      wait_drain();
      tick();
      check("valid_drops", 32'(out_valid), 32'd0);

      // Random columns against the reference model
      for (int i = 0; i < 4; i++) begin
         r = $urandom;
         send(r, ref_mix(r), e);
         wait_drain();
      end

      // Asynchronous reset in the middle of a column (k=7)
      send(32'hf20a225c, 32'h9fdc589d, e);
      for (int i = 0; i < 7; i++) tick();
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      tick();
      #2 rst = 1'b0;
      tick();
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      send(32'hdb135345, 32'h8e4da1bc, e);
      wait_drain();

      // Back-to-back columns
      out_cyc_q.delete();
      send(32'hdb135345, 32'h8e4da1bc, e);
      send(32'hf20a225c, 32'h9fdc589d, e);
      wait_drain();
      check("b2b_count", 32'(out_cyc_q.size()), 32'd2);
      if (out_cyc_q.size() == 2) begin
         v = out_cyc_q[1] - out_cyc_q[0];
         check("b2b_gap", 32'(v), 32'(B2B_GAP));
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
